// File: rtl/mic_decim_pkg.sv
// Shared types and constants for the microphone decimator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mic_decim_pkg;

  // Default configuration: 8-sample window on a 20-bit codec word, 12-bit output.
  localparam int DEF_LOG2_DECIM = 3;
  localparam int DEF_IN_WIDTH   = 20;
  localparam int DEF_OUT_WIDTH  = 12;

  // Accumulator is wide enough to hold a full window of extreme samples.
  localparam int ACC_WIDTH = DEF_IN_WIDTH + DEF_LOG2_DECIM;

  // Fractional bits carried by the DC estimate in the optional DC-removal stage.
  localparam int DC_FRAC = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  // Half an LSB of the averaged result, added before the shift so the
  // arithmetic shift rounds half-up instead of truncating toward -inf.
  function automatic int round_const(input int log2_decim);
    return (log2_decim > 0) ? (1 << (log2_decim - 1)) : 0;
  endfunction

endpackage

// File: rtl/ready_sync_edge.sv
// Two-flop synchroniser for an asynchronous level plus a rising-edge detector.
// Latency: rise is high for one cycle, 2-3 clocks after the async level rises.
// Backpressure: none; every detected rise is a single-cycle pulse.
//
// Ports:
//   clock, reset_n : destination clock, async active-low reset
//   async_in       : level from a foreign clock domain
//   rise           : one-cycle pulse on each synchronised 0->1 transition
module ready_sync_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/mic_decimator.sv
// Box-car decimator: averages 2^LOG2_DECIM codec samples, emits one rounded sample.
// Latency: valid 3 cycles after the ready edge of the window's last sample (4 with DC block).
// Backpressure: none downstream; one edge may wait as pending while busy, further ones set overrun.
//
// Ports:
//   clock, reset_n  : 27 MHz system clock, async active-low reset
//   enable          : 1 = run; 0 = clear window state and ignore ready edges
//   ready_async     : codec ready level from the bit-clock domain
//   in_data         : signed capture word, stable while ready_async is high
//   sample_out      : signed decimated sample (MSBs of the average)
//   sample_valid    : one-cycle pulse, sample_out updated in the same cycle
//   overrun         : sticky, a ready edge was lost
//   window_count    : samples accumulated in the current window
//
// Build option: define MIC_DECIM_DCBLOCK_EN to add a first-order DC-removal
// stage after the average (one extra cycle of latency, saturating output).
module mic_decimator
  import mic_decim_pkg::*;
#(
  parameter int LOG2_DECIM = DEF_LOG2_DECIM,
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        ready_async,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic signed [OUT_WIDTH-1:0] sample_out,
  output logic                        sample_valid,
  output logic                        overrun,
  output logic [LOG2_DECIM-1:0]       window_count
);

  localparam int ACC_W = IN_WIDTH + LOG2_DECIM;
  localparam logic [LOG2_DECIM-1:0] LAST_IDX = '1;
  localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(round_const(LOG2_DECIM));

  logic                       rdy_edge;
  state_t                     state;
  logic signed [IN_WIDTH-1:0] sample_reg;
  logic signed [ACC_W-1:0]    acc;
  logic [LOG2_DECIM-1:0]      count;
  logic                       pending;

  // One guard bit above the accumulator so adding the rounding constant can
  // never wrap, then an arithmetic shift back down to sample width.
  logic signed [ACC_W:0]      acc_rnd;
  logic signed [IN_WIDTH-1:0] avg;

  assign acc_rnd = {acc[ACC_W-1], acc} + RND;
  assign avg     = IN_WIDTH'(acc_rnd >>> LOG2_DECIM);

  assign window_count = count;

  ready_sync_edge u_ready_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .async_in (ready_async),
    .rise     (rdy_edge)
  );

`ifdef MIC_DECIM_DCBLOCK_EN
  localparam int DC_W = IN_WIDTH + DC_FRAC;
  localparam logic signed [IN_WIDTH-1:0] SAT_MAX = {1'b0, {(IN_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] SAT_MIN = {1'b1, {(IN_WIDTH-1){1'b0}}};

  logic                       dc_stage;
  logic signed [IN_WIDTH-1:0] avg_r;
  logic signed [DC_W-1:0]     dc_est;
  logic signed [DC_W:0]       dc_diff;
  logic signed [DC_W-1:0]     dc_next;
  logic signed [IN_WIDTH:0]   avg_dc;
  logic signed [IN_WIDTH-1:0] avg_sat;

  // Leaky integrator tracking the mean with time constant 2^DC_FRAC outputs.
  assign dc_diff = ((DC_W + 1)'(avg_r) <<< DC_FRAC) - (DC_W + 1)'(dc_est);
  assign dc_next = dc_est + DC_W'(dc_diff >>> DC_FRAC);
  assign avg_dc  = (IN_WIDTH + 1)'(avg_r) - (IN_WIDTH + 1)'(dc_est >>> DC_FRAC);

  always_comb begin
    avg_sat = avg_dc[IN_WIDTH-1:0];
    if (avg_dc[IN_WIDTH] != avg_dc[IN_WIDTH-1]) begin
      avg_sat = avg_dc[IN_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      sample_reg   <= '0;
      acc          <= '0;
      count        <= '0;
      pending      <= 1'b0;
      overrun      <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
`ifdef MIC_DECIM_DCBLOCK_EN
      dc_stage     <= 1'b0;
      avg_r        <= '0;
      dc_est       <= '0;
`endif
    end else if (!enable) begin
      // sample_out and overrun deliberately hold across a disable.
      state        <= S_IDLE;
      acc          <= '0;
      count        <= '0;
      pending      <= 1'b0;
      sample_valid <= 1'b0;
`ifdef MIC_DECIM_DCBLOCK_EN
      dc_stage     <= 1'b0;
      dc_est       <= '0;
`endif
    end else begin
      sample_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (rdy_edge | pending) begin
            sample_reg <= in_data;
            pending    <= 1'b0;
            // A fresh edge while a deferred one is being served: only one
            // of them can be captured, the other is lost.
            if (rdy_edge & pending) begin
              overrun <= 1'b1;
            end
            state <= S_ACC;
          end
        end

        S_ACC: begin
          acc <= acc + ACC_W'(sample_reg);
          // Hold at the last index; the window only restarts from S_EMIT.
          if (count == LAST_IDX) begin
            state <= S_EMIT;
          end else begin
            count <= count + 1'b1;
            state <= S_IDLE;
          end
        end

        S_EMIT: begin
`ifdef MIC_DECIM_DCBLOCK_EN
          avg_r        <= avg;
          dc_stage     <= 1'b1;
`else
          sample_out   <= OUT_WIDTH'(avg >>> (IN_WIDTH - OUT_WIDTH));
          sample_valid <= 1'b1;
`endif
          acc   <= '0;
          count <= '0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase

      // Edges arriving while busy: defer one, drop anything beyond that.
      if (rdy_edge && (state != S_IDLE)) begin
        if (pending) begin
          overrun <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end

`ifdef MIC_DECIM_DCBLOCK_EN
      if (dc_stage) begin
        sample_out   <= OUT_WIDTH'(avg_sat >>> (IN_WIDTH - OUT_WIDTH));
        sample_valid <= 1'b1;
        dc_est       <= dc_next;
        dc_stage     <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mic_decimator.sv
// Self-checking bench for mic_decimator: directed and random windows checked
// against an arithmetic reference (sum of window, round half-up, take MSBs).
module tb_mic_decimator;

  localparam int L  = 3;
  localparam int N  = 1 << L;
  localparam int IW = 20;
  localparam int OW = 12;
`ifdef MIC_DECIM_DCBLOCK_EN
  localparam int LAT_EXP = 6;
`else
  localparam int LAT_EXP = 5;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          ready_async = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic [OW-1:0] sample_out;
  logic          sample_valid;
  logic          overrun;
  logic [L-1:0]  window_count;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mic_decimator dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .ready_async  (ready_async),
    .in_data      (in_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .overrun      (overrun),
    .window_count (window_count)
  );

  // ---------------- reference model ----------------
  longint        win_q[$];
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] got_q[$];
  logic [OW-1:0] last_out = '0;
  logic          exp_overrun = 1'b0;
  longint        dc_est_m = 0;

  function automatic void model_push(input logic [IW-1:0] d);
    longint sum;
    longint avg;
    longint outv;
    win_q.push_back(longint'(signed'(d)));
    if (win_q.size() == N) begin
      sum = 0;
      foreach (win_q[i]) sum += win_q[i];
      avg = (sum + N / 2) >>> L;
      outv = avg;
`ifdef MIC_DECIM_DCBLOCK_EN
      outv = avg - (dc_est_m >>> 8);
      if (outv > 524287) outv = 524287;
      if (outv < -524288) outv = -524288;
      dc_est_m = dc_est_m + (((avg <<< 8) - dc_est_m) >>> 8);
`endif
      exp_q.push_back(OW'(outv >>> (IW - OW)));
      win_q.delete();
    end
  endfunction

  function automatic void model_clear(input logic full_reset);
    win_q.delete();
    dc_est_m = 0;
    if (full_reset) begin
      last_out    = '0;
      exp_overrun = 1'b0;
    end
  endfunction

  always @(negedge clock) begin
    if (sample_valid) got_q.push_back(sample_out);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  // All driving happens 1 time unit after a rising edge.
  task automatic pulse(input logic [IW-1:0] d, input int gap);
    in_data     = d;
    ready_async = 1'b1;
    repeat (6) @(posedge clock);
    #1 ready_async = 1'b0;
    repeat (gap) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [IW-1:0] d);
    pulse(d, int'($urandom_range(30, 4)));
    model_push(d);
  endtask

  task automatic send_rand_window();
    for (int i = 0; i < N; i++) send(IW'($urandom));
  endtask

  // Sends one sample and measures cycles from the ready rise to sample_valid.
  task automatic send_timed(input logic [IW-1:0] d, output int lat);
    lat         = -1;
    in_data     = d;
    ready_async = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock);
      @(negedge clock);
      if (sample_valid && lat < 0) lat = n;
    end
    ready_async = 1'b0;
    @(posedge clock);
    #1;
    model_push(d);
  endtask

  task automatic check_window(input string tag);
    repeat (10) @(posedge clock);
    #1;
    check({tag, " valid_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      last_out = exp_q[0];
      check({tag, " sample_out"}, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
    check({tag, " window_count"}, window_count, win_q.size());
    check({tag, " overrun"}, overrun, exp_overrun);
  endtask

  initial begin
    int lat;
    logic [IW-1:0] d;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst sample_out", sample_out, 0);
    check("rst sample_valid", sample_valid, 0);
    check("rst overrun", overrun, 0);
    check("rst window_count", window_count, 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Constant positive window; time the last sample
    for (int i = 0; i < N - 1; i++) send(20'h01000);
    send_timed(20'h01000, lat);
    check("latency", lat, LAT_EXP);
    check_window("w_pos");

    // Constant -1: rounds back to -1
    for (int i = 0; i < N; i++) send(20'hFFFFF);
    check_window("w_neg1");

    // Alternating +/- cancels
    for (int i = 0; i < N; i++) send((i % 2 == 0) ? 20'h00100 : 20'hFFF00);
    check_window("w_alt");

    // Full-scale positive, must not wrap
    for (int i = 0; i < N; i++) send(20'h7FFFF);
    check_window("w_max");

    // Random windows
    for (int w = 0; w < 6; w++) send_rand_window();
    check_window("w_rand");

    // Reset in the middle of a window
    for (int i = 0; i < 5; i++) send(IW'($urandom));
    check("mid window_count", window_count, win_q.size());
    reset_n = 1'b0;
    model_clear(1'b1);
    repeat (2) @(posedge clock);
    #1;
    check("mid_rst sample_out", sample_out, 0);
    check("mid_rst window_count", window_count, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) send(20'h02000);
    check_window("w_after_rst");

    // Back-to-back edges: capture, defer, then a collision that is dropped
    d = IW'($urandom);
    in_data = d;
    @(negedge clock);
    force dut.rdy_edge = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    release dut.rdy_edge;
    @(posedge clock);
    #1;
    model_push(d);
    model_push(d);
    exp_overrun = 1'b1;
    check_window("burst");

    // Disable mid-window: window discarded, edges ignored, output held
    for (int i = 0; i < 3; i++) send(IW'($urandom));
    enable = 1'b0;
    model_clear(1'b0);
    pulse(IW'($urandom), 6);
    repeat (4) @(posedge clock);
    #1;
    check("dis window_count", window_count, 0);
    check("dis no_valid", got_q.size(), 0);
    check("dis sample_out_hold", sample_out, last_out);
    check("dis overrun_hold", overrun, 1);
    enable = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    send_rand_window();
    check_window("w_after_dis");
    send_rand_window();
    send_rand_window();
    check_window("w_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
